i2c_arbiter: RTL

Round-robin arbiter that shares one I2C master (`i2c_master`) among the swerve-rotation controllers, so that four angle-sensor links can use a single SCL/SDA pair. Each requester presents a complete transaction descriptor and holds a level request. The arbiter grants one requester, launches the transaction on the master, waits for completion, and returns read data and status to that requester with a one-cycle acknowledge. It sits between the `pwm_ctrl` instances and the shared `i2c_master` in the subsystem top level.

---
 rtl/i2c_arb_pkg.sv | 7 +
 rtl/rr_pick.sv | 26 ++
 rtl/i2c_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: state encoding and field widths shared by the I2C arbiter.
package i2c_arb_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_ISSUE, S_WAIT, S_RELEASE} state_e;
  localparam int DEV_W = 7;
  localparam int BYTE_W = 8;
  localparam int WDOG_W = 20;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; searches from last+1 upward with wrap.
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  win_o,
  output logic [IW-1:0] idx_o
);
  logic [IW-1:0] j;
  // Walk the farthest offset first so the nearest requester after last overwrites it.
  always_comb begin
    win_o = '0;
    idx_o = '0;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(last_i) + k) % N);
      if (req_i[j]) begin
        win_o = '0;
        win_o[j] = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin sharing of one I2C master among NUM_REQ requesters.
// Define I2C_ARB_TIMEOUT_EN to build the transaction watchdog and m_abort.
module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [DEV_W*NUM_REQ-1:0]  req_dev,
  input  logic [BYTE_W*NUM_REQ-1:0] req_reg,
  input  logic [NUM_REQ-1:0]        req_rd,
  input  logic [BYTE_W*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        err,
  output logic [BYTE_W-1:0]         rdata,
  output logic                      m_start,
  output logic [DEV_W-1:0]          m_dev,
  output logic [BYTE_W-1:0]         m_reg,
  output logic                      m_rd,
  output logic [BYTE_W-1:0]         m_wdata,
  input  logic                      m_done,
  input  logic                      m_nack,
  input  logic [BYTE_W-1:0]         m_rdata,
  output logic                      m_abort
);
  localparam int IW = $clog2(NUM_REQ);
  state_e state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, win;
  logic [IW-1:0] gidx_q, gidx_d, last_q, last_d, win_idx;
  logic [DEV_W-1:0] dev_q, dev_d;
  logic [BYTE_W-1:0] reg_q, reg_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic rd_q, rd_d, err_q, err_d, expire;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i(req),
    .last_i(last_q),
    .win_o(win),
    .idx_o(win_idx)
  );
`ifdef I2C_ARB_TIMEOUT_EN
  logic [WDOG_W-1:0] cnt_q, cnt_d;
  assign expire = cnt_q == WDOG_W'(TIMEOUT_CYCLES - 1);
  always_comb cnt_d = state_q == S_ISSUE ? '0 : state_q == S_WAIT ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d = gidx_q;
    last_d = last_q;
    dev_d = dev_q;
    reg_d = reg_q;
    rd_d = rd_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
    case (state_q)
      S_IDLE: if (|req) begin
        grant_d = win;
        gidx_d = win_idx;
        state_d = S_LATCH;
      end
      S_LATCH: begin
        for (int i = 0; i < NUM_REQ; i++)
          if (grant_q[i]) begin
            dev_d = req_dev[i*DEV_W +: DEV_W];
            reg_d = req_reg[i*BYTE_W +: BYTE_W];
            rd_d = req_rd[i];
            wdata_d = req_wdata[i*BYTE_W +: BYTE_W];
          end
        state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      // m_done takes priority over a watchdog expiry in the same cycle.
      S_WAIT: if (m_done) begin
        rdata_d = rd_q ? m_rdata : '0;
        err_d = m_nack;
        state_d = S_RELEASE;
      end else if (expire) begin
        rdata_d = '0;
        err_d = 1'b1;
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        last_d = gidx_q;
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      gidx_q <= '0;
      last_q <= IW'(NUM_REQ - 1);
      dev_q <= '0;
      reg_q <= '0;
      rd_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q <= gidx_d;
      last_q <= last_d;
      dev_q <= dev_d;
      reg_q <= reg_d;
      rd_q <= rd_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  assign grant = grant_q;
  assign ack = state_q == S_RELEASE ? grant_q : '0;
  assign err = state_q == S_RELEASE ? grant_q & {NUM_REQ{err_q}} : '0;
  assign rdata = state_q == S_RELEASE ? rdata_q : '0;
  assign m_start = state_q == S_ISSUE;
  assign m_dev = dev_q;
  assign m_reg = reg_q;
  assign m_rd = rd_q;
  assign m_wdata = wdata_q;
  assign m_abort = state_q == S_WAIT && expire && !m_done;
endmodule
